// File: rtl/ci_cam_emu.sv
// ci_cam_emu: CI TS loopback CAM emulator; validates host packets into a two-slot
// ping-pong buffer and replays them with a gap. Optional macro CAM_EMU_XOR_EN adds xor_key.
module ci_cam_emu #(
  parameter int unsigned PKT_LEN    = 188,
  parameter int unsigned GAP_CYCLES = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'h47
) (
  input  logic        clk_9,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  CI_MDI,
  input  logic        CI_MISTRT,
  input  logic        CI_MIVAL,
`ifdef CAM_EMU_XOR_EN
  input  logic [7:0]  xor_key,
`endif
  output logic [7:0]  CI_MDO,
  output logic        CI_MCLKO,
  output logic        CI_MOSTRT,
  output logic        CI_MOVAL,
  output logic [23:0] pkts_in,
  output logic [23:0] pkts_out,
  output logic [23:0] pkts_drop
);
  localparam int unsigned AW = $clog2(2 * PKT_LEN);
  localparam int unsigned CW = $clog2(PKT_LEN + 2);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST     = CW'(PKT_LEN - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic {CAP_IDLE, CAP_RUN} cap_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_PREFETCH, TX_SEND, TX_GAP} tx_state_t;

  cap_state_t    cap_state_q, cap_state_d;
  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
  logic [1:0]    full_q, full_d;
  logic [23:0]   pkts_in_q, pkts_in_d, pkts_out_q, pkts_out_d, pkts_drop_q, pkts_drop_d;
  logic [7:0]    mdo_q, mdo_d;
  logic          mostrt_q, mostrt_d, moval_q, moval_d;

  logic          wr_en, cap_done, tx_free, slot_free, start_ok;
  logic [1:0]    drop_inc;
  logic [CW-1:0] wr_idx, rd_idx;
  logic [7:0]    mem [0:2*PKT_LEN-1];
  logic [7:0]    rd_data_q;

  function automatic logic [AW-1:0] slot_addr(input logic slot, input logic [CW-1:0] idx);
    return AW'(idx) + (slot ? AW'(PKT_LEN) : '0);
  endfunction

  assign CI_MCLKO  = ~clk_9;
  assign CI_MDO    = mdo_q;
  assign CI_MOSTRT = mostrt_q;
  assign CI_MOVAL  = moval_q;
  assign pkts_in   = pkts_in_q;
  assign pkts_out  = pkts_out_q;
  assign pkts_drop = pkts_drop_q;

  // A slot drained by transmit this cycle is already usable by a start byte.
  assign slot_free = ~full_q[wr_slot_q] | (tx_free & (rd_slot_q == wr_slot_q));
  assign start_ok  = enable && (CI_MDI == SYNC_BYTE) && slot_free;

  always_ff @(posedge clk_9) begin
    if (wr_en) mem[slot_addr(wr_slot_q, wr_idx)] <= CI_MDI;
    rd_data_q <= mem[slot_addr(rd_slot_q, rd_idx)];
  end

  always_ff @(posedge clk_9 or posedge reset) begin
    if (reset) begin
      cap_state_q <= CAP_IDLE;
      tx_state_q  <= TX_IDLE;
      wr_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      wr_slot_q   <= 1'b0;
      rd_slot_q   <= 1'b0;
      full_q      <= '0;
      pkts_in_q   <= '0;
      pkts_out_q  <= '0;
      pkts_drop_q <= '0;
      mdo_q       <= '0;
      mostrt_q    <= 1'b0;
      moval_q     <= 1'b0;
    end else begin
      cap_state_q <= cap_state_d;
      tx_state_q  <= tx_state_d;
      wr_cnt_q    <= wr_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      wr_slot_q   <= wr_slot_d;
      rd_slot_q   <= rd_slot_d;
      full_q      <= full_d;
      pkts_in_q   <= pkts_in_d;
      pkts_out_q  <= pkts_out_d;
      pkts_drop_q <= pkts_drop_d;
      mdo_q       <= mdo_d;
      mostrt_q    <= mostrt_d;
      moval_q     <= moval_d;
    end
  end

  // Capture: an aborted short packet and a rejected restart byte each count as a drop.
  always_comb begin
    cap_state_d = cap_state_q;
    wr_cnt_d    = wr_cnt_q;
    wr_slot_d   = wr_slot_q;
    wr_en       = 1'b0;
    wr_idx      = '0;
    cap_done    = 1'b0;
    drop_inc    = 2'd0;
    if (CI_MIVAL) begin
      if (CI_MISTRT) begin
        if (cap_state_q == CAP_RUN) drop_inc = 2'd1;
        if (start_ok) begin
          wr_en       = 1'b1;
          wr_cnt_d    = CW'(1);
          cap_state_d = CAP_RUN;
        end else begin
          drop_inc    = drop_inc + 2'd1;
          cap_state_d = CAP_IDLE;
        end
      end else if (cap_state_q == CAP_RUN) begin
        wr_en  = 1'b1;
        wr_idx = wr_cnt_q;
        if (wr_cnt_q == LAST) begin
          cap_done    = 1'b1;
          wr_slot_d   = ~wr_slot_q;
          cap_state_d = CAP_IDLE;
        end else begin
          wr_cnt_d = wr_cnt_q + CW'(1);
        end
      end
    end
  end

  // Transmit next state; the RAM address runs one byte ahead of the output register.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rd_slot_d  = rd_slot_q;
    tx_free    = 1'b0;
    rd_idx     = '0;
    case (tx_state_q)
      TX_IDLE:     if (full_q[rd_slot_q]) tx_state_d = TX_PREFETCH;
      TX_PREFETCH: begin
        rd_idx     = CW'(1);
        tx_cnt_d   = '0;
        tx_state_d = TX_SEND;
      end
      TX_SEND: begin
        if (tx_cnt_q < CW'(PKT_LEN - 2)) rd_idx = tx_cnt_q + CW'(2);
        if (tx_cnt_q == LAST) begin
          tx_free   = 1'b1;
          rd_slot_d = ~rd_slot_q;
          gap_cnt_d = GAP_INIT;
          tx_state_d = (GAP_CYCLES == 0) ? TX_IDLE : TX_GAP;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_GAP: begin
        if (gap_cnt_q == '0) tx_state_d = TX_IDLE;
        else gap_cnt_d = gap_cnt_q - GW'(1);
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    mdo_d    = '0;
    mostrt_d = 1'b0;
    moval_d  = 1'b0;
    case (tx_state_q)
      TX_PREFETCH: begin
        mdo_d    = rd_data_q;
        mostrt_d = 1'b1;
        moval_d  = 1'b1;
      end
      TX_SEND: begin
        if (tx_cnt_q != LAST) begin
          mdo_d   = rd_data_q;
          moval_d = 1'b1;
`ifdef CAM_EMU_XOR_EN
          // Next byte index is tx_cnt_q+1; header bytes 0..3 pass unmodified.
          if (tx_cnt_q >= CW'(3)) mdo_d = rd_data_q ^ xor_key;
`endif
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (cap_done) full_d[wr_slot_q] = 1'b1;
    if (tx_free)  full_d[rd_slot_q] = 1'b0;
    pkts_in_d   = pkts_in_q + {23'd0, cap_done};
    pkts_out_d  = pkts_out_q + {23'd0, tx_free};
    pkts_drop_d = pkts_drop_q + {22'd0, drop_inc};
  end
endmodule

// File: tb/tb_ci_cam_emu.sv
// Self-checking bench for ci_cam_emu: packet-level reference model plus output monitor.
module tb_ci_cam_emu;
  localparam int PKT_LEN    = 188;
  localparam int GAP_CYCLES = 4;
  localparam logic [7:0] SYNC = 8'h47;
  localparam time P = 10;

  logic        clk_9 = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  CI_MDI = '0;
  logic        CI_MISTRT = 1'b0;
  logic        CI_MIVAL = 1'b0;
`ifdef CAM_EMU_XOR_EN
  logic [7:0]  xor_key = 8'h5A;
`endif
  logic [7:0]  CI_MDO;
  logic        CI_MCLKO, CI_MOSTRT, CI_MOVAL;
  logic [23:0] pkts_in, pkts_out, pkts_drop;

  int total = 0;
  int bad = 0;

  ci_cam_emu #(.PKT_LEN(PKT_LEN), .GAP_CYCLES(GAP_CYCLES), .SYNC_BYTE(SYNC)) dut (
    .clk_9(clk_9), .reset(reset), .enable(enable),
    .CI_MDI(CI_MDI), .CI_MISTRT(CI_MISTRT), .CI_MIVAL(CI_MIVAL),
`ifdef CAM_EMU_XOR_EN
    .xor_key(xor_key),
`endif
    .CI_MDO(CI_MDO), .CI_MCLKO(CI_MCLKO), .CI_MOSTRT(CI_MOSTRT), .CI_MOVAL(CI_MOVAL),
    .pkts_in(pkts_in), .pkts_out(pkts_out), .pkts_drop(pkts_drop)
  );

  always #(P/2) clk_9 = ~clk_9;

  // Reference model: packets are lists of bytes; the buffer holds at most two full packets,
  // and one is released on the edge after its last byte has appeared at the output.
  logic [7:0] m_cur[$];
  logic [7:0] exp_bytes[$];
  bit m_cap = 0;
  int m_full = 0, m_freed = 0, m_in = 0, m_drop = 0;

  logic [7:0] obs_bytes[$];
  int  obs_gap[$];
  time obs_t[$];
  int  obs_last_cnt = 0, obs_broken = 0, mon_cnt = 0, idle_cnt = 0;
  time last_t = 0;

  initial forever begin
    @(posedge clk_9);
    if (reset) begin
      m_cur.delete(); exp_bytes.delete();
      m_cap = 0; m_full = 0; m_freed = 0; m_in = 0; m_drop = 0;
    end else begin
      if (obs_last_cnt != m_freed) begin
        m_freed++;
        m_full--;
      end
      if (CI_MIVAL) begin
        if (CI_MISTRT) begin
          if (m_cap) begin m_drop++; m_cap = 0; end
          if (enable && CI_MDI == SYNC && m_full < 2) begin
            m_cap = 1;
            m_cur.delete();
            m_cur.push_back(CI_MDI);
          end else begin
            m_drop++;
          end
        end else if (m_cap) begin
          m_cur.push_back(CI_MDI);
          if (m_cur.size() == PKT_LEN) begin
            for (int i = 0; i < PKT_LEN; i++) begin
              logic [7:0] b;
              b = m_cur[i];
`ifdef CAM_EMU_XOR_EN
              if (i >= 4) b = b ^ xor_key;
`endif
              exp_bytes.push_back(b);
            end
            m_full++; m_in++; m_cap = 0;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk_9);
    if (reset) begin
      obs_bytes.delete(); obs_gap.delete(); obs_t.delete();
      obs_last_cnt = 0; obs_broken = 0; mon_cnt = 0; idle_cnt = 0;
    end else if (CI_MOVAL) begin
      if (CI_MOSTRT) begin
        if (mon_cnt != 0) obs_broken++;
        obs_gap.push_back(idle_cnt);
        obs_t.push_back($time);
        mon_cnt = 0;
      end else if (mon_cnt == 0) begin
        obs_broken++;
      end
      obs_bytes.push_back(CI_MDO);
      mon_cnt++;
      idle_cnt = 0;
      if (mon_cnt == PKT_LEN) begin obs_last_cnt++; mon_cnt = 0; end
    end else begin
      if (mon_cnt != 0) obs_broken++;
      idle_cnt++;
    end
  end

  initial begin
    #(P * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic [7:0] d, input logic s, input logic v);
    @(negedge clk_9);
    CI_MDI = d; CI_MISTRT = s; CI_MIVAL = v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'($urandom), 1'b0, 1'b0);
  endtask

  // ramp=1 sends byte i = i after the first byte; otherwise random payload.
  task automatic send_pkt(input logic [7:0] first, input int len, input int gap_pct, input bit ramp);
    for (int i = 0; i < len; i++) begin
      while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) drive(8'($urandom), 1'b0, 1'b0);
      drive((i == 0) ? first : (ramp ? 8'(i) : 8'($urandom)), i == 0, 1'b1);
    end
    last_t = $time + P/2;
  endtask

  task automatic do_reset();
    @(negedge clk_9);
    reset = 1'b1; CI_MIVAL = 1'b0; CI_MISTRT = 1'b0;
    repeat (2) @(posedge clk_9);
    @(negedge clk_9);
    reset = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 0;
    drive(8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_9);
      if (obs_bytes.size() == exp_bytes.size() && !CI_MOVAL && !m_cap) begin ok = 1; break; end
    end
    repeat (20) @(negedge clk_9);
  endtask

  function automatic int first_diff();
    for (int i = 0; i < exp_bytes.size(); i++)
      if (obs_bytes[i] !== exp_bytes[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    do_reset();
    @(negedge clk_9);
    total++; if (CI_MDO !== 8'h00)   begin bad++; $display("FAIL reset_mdo: got %h want 00", CI_MDO); end
    total++; if (CI_MOSTRT !== 1'b0) begin bad++; $display("FAIL reset_mostrt: got %b want 0", CI_MOSTRT); end
    total++; if (CI_MOVAL !== 1'b0)  begin bad++; $display("FAIL reset_moval: got %b want 0", CI_MOVAL); end
    total++; if (pkts_in !== 24'd0 || pkts_out !== 24'd0 || pkts_drop !== 24'd0) begin
      bad++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", pkts_in, pkts_out, pkts_drop);
    end
    total++; if (CI_MCLKO !== ~clk_9) begin bad++; $display("FAIL mclko: got %b want %b", CI_MCLKO, ~clk_9); end
  endtask

  task automatic test_single();
    bit ok;
    int d;
    do_reset();
    enable = 1'b1;
    send_pkt(SYNC, PKT_LEN, 0, 1'b1);
    wait_drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL single_drain: got %0d bytes want %0d", obs_bytes.size(), exp_bytes.size()); end
    // Full at edge N, first byte registered at N+2, sampled half a period later.
    total++; if (obs_t.size() != 1 || obs_t[0] != last_t + 2*P + P/2) begin
      bad++; $display("FAIL single_latency: got %0t want %0t", (obs_t.size() > 0) ? obs_t[0] : 0, last_t + 2*P + P/2);
    end
    d = first_diff();
    total++; if (obs_bytes.size() != PKT_LEN || d != -1 || obs_bytes[0] !== SYNC) begin
      bad++; $display("FAIL single_data: got size %0d diff@%0d want size %0d diff@-1", obs_bytes.size(), d, PKT_LEN);
    end
    total++; if (pkts_in !== 24'd1 || pkts_out !== 24'd1 || pkts_drop !== 24'd0) begin
      bad++; $display("FAIL single_counters: got %0d/%0d/%0d want 1/1/0", pkts_in, pkts_out, pkts_drop);
    end
  endtask

  task automatic test_bad_sync();
    bit ok;
    int d;
    do_reset();
    enable = 1'b1;
    send_pkt(8'h48, PKT_LEN, 0, 1'b0);
    idle(3);
    enable = 1'b0;
    send_pkt(SYNC, PKT_LEN, 0, 1'b0);
    idle(3);
    enable = 1'b1;
    send_pkt(SYNC, PKT_LEN, 0, 1'b0);
    wait_drain(ok);
    d = first_diff();
    total++; if (!ok || obs_bytes.size() != PKT_LEN || d != -1) begin
      bad++; $display("FAIL badsync_data: got size %0d diff@%0d want size %0d diff@-1", obs_bytes.size(), d, PKT_LEN);
    end
    total++; if (pkts_drop !== 24'd2 || pkts_in !== 24'd1 || pkts_out !== 24'd1) begin
      bad++; $display("FAIL badsync_counters: got drop=%0d in=%0d out=%0d want 2/1/1", pkts_drop, pkts_in, pkts_out);
    end
  endtask

  task automatic test_short();
    bit ok;
    int d;
    do_reset();
    enable = 1'b1;
    send_pkt(SYNC, 100, 0, 1'b0);
    send_pkt(SYNC, PKT_LEN, 0, 1'b0);
    wait_drain(ok);
    d = first_diff();
    total++; if (!ok || obs_bytes.size() != PKT_LEN || d != -1) begin
      bad++; $display("FAIL short_data: got size %0d diff@%0d want size %0d diff@-1", obs_bytes.size(), d, PKT_LEN);
    end
    total++; if (pkts_drop !== 24'd1 || pkts_in !== 24'd1 || pkts_out !== 24'd1) begin
      bad++; $display("FAIL short_counters: got drop=%0d in=%0d out=%0d want 1/1/1", pkts_drop, pkts_in, pkts_out);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d;
    do_reset();
    enable = 1'b1;
    repeat (3) send_pkt(SYNC, PKT_LEN, 0, 1'b0);
    wait_drain(ok);
    d = first_diff();
    total++; if (!ok || obs_bytes.size() != exp_bytes.size() || d != -1 || obs_broken != 0) begin
      bad++; $display("FAIL b2b_data: got size %0d diff@%0d broken %0d want size %0d diff@-1 broken 0",
                      obs_bytes.size(), d, obs_broken, exp_bytes.size());
    end
    total++; if (pkts_drop !== 24'(m_drop) || pkts_in !== 24'(m_in) || pkts_out !== 24'(exp_bytes.size() / PKT_LEN)) begin
      bad++; $display("FAIL b2b_counters: got drop=%0d in=%0d out=%0d want %0d/%0d/%0d",
                      pkts_drop, pkts_in, pkts_out, m_drop, m_in, exp_bytes.size() / PKT_LEN);
    end
    // Next packet already full: GAP_CYCLES in GAP plus one IDLE and one PREFETCH cycle.
    total++; if (obs_gap.size() < 2 || obs_gap[1] != GAP_CYCLES + 2) begin
      bad++; $display("FAIL b2b_gap: got %0d want %0d", (obs_gap.size() > 1) ? obs_gap[1] : -1, GAP_CYCLES + 2);
    end

    do_reset();
    repeat (2) send_pkt(SYNC, PKT_LEN, 0, 1'b0);
    idle(12);
    send_pkt(SYNC, PKT_LEN, 0, 1'b0);
    wait_drain(ok);
    d = first_diff();
    total++; if (!ok || obs_bytes.size() != 3 * PKT_LEN || d != -1 || obs_broken != 0) begin
      bad++; $display("FAIL spaced_data: got size %0d diff@%0d broken %0d want size %0d diff@-1 broken 0",
                      obs_bytes.size(), d, obs_broken, 3 * PKT_LEN);
    end
    total++; if (pkts_drop !== 24'd0 || pkts_in !== 24'd3 || pkts_out !== 24'd3) begin
      bad++; $display("FAIL spaced_counters: got drop=%0d in=%0d out=%0d want 0/3/3", pkts_drop, pkts_in, pkts_out);
    end
    total++; if (obs_gap.size() != 3 || obs_gap[2] < GAP_CYCLES) begin
      bad++; $display("FAIL spaced_gap: got %0d want >= %0d", (obs_gap.size() > 2) ? obs_gap[2] : -1, GAP_CYCLES);
    end
  endtask

  task automatic test_gaps_and_reset();
    bit ok, seen;
    int d;
    do_reset();
    enable = 1'b1;
    send_pkt(SYNC, PKT_LEN, 50, 1'b0);
    wait_drain(ok);
    d = first_diff();
    total++; if (!ok || obs_bytes.size() != PKT_LEN || d != -1 || obs_broken != 0) begin
      bad++; $display("FAIL gaps_data: got size %0d diff@%0d broken %0d want size %0d diff@-1 broken 0",
                      obs_bytes.size(), d, obs_broken, PKT_LEN);
    end
    total++; if (pkts_in !== 24'd1 || pkts_out !== 24'd1) begin
      bad++; $display("FAIL gaps_counters: got in=%0d out=%0d want 1/1", pkts_in, pkts_out);
    end

    send_pkt(SYNC, PKT_LEN, 0, 1'b0);
    idle(1);
    seen = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_9);
      if (CI_MOVAL) begin seen = 1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL midsend_start: got moval=0 want 1 within 400 cycles"); end
    repeat (20) @(negedge clk_9);
    #1 reset = 1'b1;
    #1;
    total++; if (CI_MOVAL !== 1'b0 || CI_MOSTRT !== 1'b0 || CI_MDO !== 8'h00) begin
      bad++; $display("FAIL midsend_outputs: got moval=%b mostrt=%b mdo=%h want 0/0/00", CI_MOVAL, CI_MOSTRT, CI_MDO);
    end
    total++; if (pkts_in !== 24'd0 || pkts_out !== 24'd0 || pkts_drop !== 24'd0) begin
      bad++; $display("FAIL midsend_counters: got %0d/%0d/%0d want 0/0/0", pkts_in, pkts_out, pkts_drop);
    end
    repeat (2) @(posedge clk_9);
    @(negedge clk_9);
    reset = 1'b0;
    repeat (400) @(negedge clk_9);
    total++; if (obs_bytes.size() != 0 || pkts_out !== 24'd0) begin
      bad++; $display("FAIL midsend_discard: got %0d bytes out=%0d want 0/0", obs_bytes.size(), pkts_out);
    end
  endtask

`ifdef CAM_EMU_XOR_EN
  task automatic test_xor();
    bit ok;
    int nbad;
    logic [7:0] want;
    do_reset();
    enable = 1'b1;
    xor_key = 8'hFF;
    send_pkt(SYNC, PKT_LEN, 0, 1'b1);
    wait_drain(ok);
    nbad = 0;
    for (int i = 0; i < PKT_LEN; i++) begin
      want = (i == 0) ? SYNC : ((i < 4) ? 8'(i) : ~8'(i));
      if (i >= obs_bytes.size() || obs_bytes[i] !== want) nbad++;
    end
    total++; if (!ok || obs_bytes.size() != PKT_LEN || nbad != 0) begin
      bad++; $display("FAIL xor_data: got size %0d wrong %0d want size %0d wrong 0", obs_bytes.size(), nbad, PKT_LEN);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_bad_sync();
    test_short();
    test_back_to_back();
    test_gaps_and_reset();
`ifdef CAM_EMU_XOR_EN
    test_xor();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
